// File: rtl/plot_arb_pkg.sv
// rtl/plot_arb_pkg.sv - shared widths, screen defaults and state encoding for plot_arbiter
package plot_arb_pkg;
  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLEAR = 2'd2
  } state_t;
endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// rtl/plot_arbiter_rr_pick.sv - combinational round-robin selector (module rr_pick)
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any
);
  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] sel;

  // Prefer requesters at or above ptr; fall back to the lowest overall on wrap.
  assign mask   = ~((N'(1) << ptr) - N'(1));
  assign masked = req & mask;
  assign sel    = (|masked) ? masked : req;
  assign grant  = sel & (~sel + N'(1));
  assign any    = |req;
endmodule

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - VGA pixel-port arbiter with clear sequencer; optional PLOT_ARBITER_DROP_STATS_EN
module plot_arbiter
  import plot_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           gnt,
  input  logic                         clear_start,
  input  logic [COLOUR_W-1:0]          clear_colour,
  output logic                         clear_busy,
  output logic                         clear_done,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot,
  output logic [15:0]                  drop_count
);
  localparam int PW = $clog2(NUM_REQ);

  state_t                state;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         owner;
  logic [PW-1:0]         pick_idx;
  logic [NUM_REQ-1:0]    pick;
  logic                  any_req;
  logic                  pending;
  logic [COLOUR_W-1:0]   clr_col;
  logic [X_W-1:0]        cx;
  logic [Y_W-1:0]        cy;
  logic [X_W-1:0]        rx [NUM_REQ];
  logic [Y_W-1:0]        ry [NUM_REQ];
  logic [COLOUR_W-1:0]   rc [NUM_REQ];
  logic                  in_range;
  logic                  start_ok;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rx[g] = req_x[g*X_W +: X_W];
    assign ry[g] = req_y[g*Y_W +: Y_W];
    assign rc[g] = req_colour[g*COLOUR_W +: COLOUR_W];
  end

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick),
    .any   (any_req)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  assign in_range = ({1'b0, rx[owner]} < (X_W+1)'(SCREEN_W)) &&
                    ({1'b0, ry[owner]} < (Y_W+1)'(SCREEN_H));
  assign start_ok = clear_start && !clear_busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt        <= '0;
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      pending    <= 1'b0;
      clr_col    <= '0;
      ptr        <= '0;
      owner      <= '0;
      cx         <= '0;
      cy         <= '0;
    end else begin
      plot       <= 1'b0;
      clear_done <= 1'b0;
      if (start_ok) begin
        pending    <= 1'b1;
        clear_busy <= 1'b1;
        clr_col    <= clear_colour;
      end else if (clear_done) begin
        clear_busy <= 1'b0;
      end
      case (state)
        IDLE: begin
          gnt <= '0;
          // A clear arriving alongside a request still wins this cycle.
          if (pending || start_ok) begin
            state   <= CLEAR;
            pending <= 1'b0;
            cx      <= '0;
            cy      <= '0;
          end else if (any_req) begin
            state <= BURST;
            gnt   <= pick;
            owner <= pick_idx;
          end
        end
        BURST: begin
          if (req[owner]) begin
            x      <= rx[owner];
            y      <= ry[owner];
            colour <= rc[owner];
            plot   <= in_range;
          end
          if (!req[owner] || req_last[owner]) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= (owner == PW'(NUM_REQ-1)) ? '0 : owner + 1'b1;
          end
        end
        CLEAR: begin
          x      <= cx;
          y      <= cy;
          colour <= clr_col;
          plot   <= 1'b1;
          if (cx == X_W'(SCREEN_W-1)) begin
            cx <= '0;
            if (cy == Y_W'(SCREEN_H-1)) begin
              state      <= IDLE;
              clear_done <= 1'b1;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLOT_ARBITER_DROP_STATS_EN
  logic drop_inc;
  assign drop_inc = (state == BURST) && req[owner] && !in_range;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      drop_count <= '0;
    else if (drop_inc && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`else
  assign drop_count = '0;
`endif
endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
Shares the single VGA adapter pixel-write port (x, y, colour, plot) between NUM_REQ drawing engines, such as a box filler, a sprite drawer and a text writer. It also contains a built-in full-screen clear sequencer with top priority. Requesters win bursts by round-robin arbitration. Every accepted pixel is presented to the adapter exactly one cycle later.

Parameters:
NUM_REQ, 3, number of requester ports (2..8)
SCREEN_W, 160, horizontal pixel count; valid x is 0..SCREEN_W-1
SCREEN_H, 120, vertical pixel count; valid y is 0..SCREEN_H-1

Ports:
clock  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester pixel valid
req_x  in  NUM_REQ*8  packed x coordinates; requester i uses bits [8i+7:8i]
req_y  in  NUM_REQ*7  packed y coordinates
req_colour  in  NUM_REQ*3  packed colours
req_last  in  NUM_REQ  marks the final pixel of a burst
gnt  out  NUM_REQ  one-hot grant; a pixel is accepted when gnt[i]&req[i]
clear_start  in  1  single-cycle pulse requesting a full-screen clear
clear_colour  in  3  fill colour, sampled on clear_start
clear_busy  out  1  high while a clear is pending or running
clear_done  out  1  single-cycle pulse with the final clear pixel
x  out  8  pixel x to the adapter (registered)
y  out  7  pixel y to the adapter (registered)
colour  out  3  pixel colour to the adapter (registered)
plot  out  1  write strobe to the adapter (registered)
drop_count  out  16  count of out-of-range pixels (see Optional Feature)

Behaviour:
- Reset (asynchronous, reset=0) clears everything:
  - state=IDLE, gnt=0, plot=0, x=y=colour=0;
  - clear_busy=0, clear_done=0, clear pending=0;
  - round-robin pointer=0, drop_count=0.
- Reset mid-burst or mid-clear aborts the operation immediately. Nothing resumes afterwards.
- State IDLE (gnt=0, plot=0 next cycle):
  - clear pending → CLEAR.
  - else any req → BURST. Owner is the first requester with req=1, searching from ptr upward with wrap. gnt[owner]=1 from the next cycle.
  - else stay in IDLE.
- State BURST (gnt=onehot(owner)):
  - Accept when req[owner]=1. On the next cycle, x/y/colour = that requester's fields and plot=1.
  - Out-of-range pixel (x>=SCREEN_W or y>=SCREEN_H): still accepted (consumed), but plot=0 that output cycle and drop_count increments.
  - Accepted beat with req_last=1, or req[owner]=0 → IDLE; ptr=owner+1 (wraps).
  - Requests from other requesters are ignored until the burst ends.
- State CLEAR (gnt=0):
  - Internal counters start at cx=0, cy=0.
  - Each cycle emits plot=1 with the current x=cx, y=cy, colour=latched clear_colour.
  - cx increments; at SCREEN_W-1 it wraps to 0 and cy increments.
  - After (SCREEN_W-1, SCREEN_H-1) → IDLE. Total is exactly SCREEN_W*SCREEN_H plot cycles (19200 at default).
  - clear_done=1 in the same cycle as the final plot.
  - clear_busy falls the cycle after clear_done.
- clear_start timing:
  - Sets pending and clear_busy on the next edge in any state.
  - During BURST it is serviced right after the burst ends; a burst is never preempted.
  - clear_start while pending or during CLEAR is ignored. The colour is not re-sampled.
  - clear_start in the same cycle as an IDLE request: the request waits and the clear runs first.
- Latency:
  - req rises in IDLE at cycle N → gnt at N+1 → first plot at N+2.
  - A back-to-back burst sustains 1 pixel/cycle.
  - One dead cycle (IDLE) separates consecutive bursts.
- Output plot is the registered value only; no combinational path runs from req to plot.

Optional Feature:
PLOT_ARBITER_DROP_STATS_EN
- Defined: drop_count is a 16-bit saturating counter (holds at 16'hFFFF) of out-of-range accepted pixels.
- Undefined: the range check remains (out-of-range pixels are still dropped with plot=0), drop_count is tied to 0 and no counter flops are built.

Decomposition:
- Package plot_arb_pkg: SCREEN_W/SCREEN_H defaults, X_W=8, Y_W=7, COLOUR_W=3, and the state encoding (IDLE=2'd0, BURST=2'd1, CLEAR=2'd2).
- Sub-module rr_pick: combinational round-robin selector with inputs req and ptr and outputs a one-hot winner plus an any-request flag. The arbiter instantiates it once.

Test Plan:
- Reset mid-CLEAR at pixel (50,30) → plot=0, clear_busy=0 immediately. Only a fresh clear_start restarts the clear, and it begins at (0,0).
- req[0] only, 4-pixel burst (10,5)..(13,5), colour 3'b101, req_last on the 4th → gnt[0] one cycle after req; plots on 4 consecutive cycles with the matching x/y/colour; then gnt=0 for one cycle.
- req[0..2] held continuously, single-pixel bursts → grant order 0,1,2,0,1,2. Each grant is separated by one IDLE cycle.
- clear_start, colour 3'b010, during requester 1's burst → burst completes, then 19200 plots of colour 3'b010 ending at (159,119). clear_done coincides with the last plot; requests are served afterwards.
- Requester 2 sends (160,0), then (5,120), then (5,5) → first two are consumed with plot=0 and the third plots. drop_count=2 with PLOT_ARBITER_DROP_STATS_EN, 0 without.
